// File: rtl/arbitro_pkg.sv
// Shared definitions for the priority arbiter: FSM encoding, idle code,
// invalid-code test and the legacy 3-bit code ranking.
package arbitro_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int CODE_IDLE = 0;

  // A code is invalid when all of its 'width' low bits are ones.
  function automatic logic is_invalid(input logic [31:0] code, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (code & mask) == mask;
  endfunction

  // Legacy comparator ordering: 000 < 110 < 001 < 011 < 101; unused codes rank lowest.
  function automatic logic [2:0] legado3_para_rank(input logic [2:0] code);
    logic [2:0] rank;
    case (code)
      3'b110:  rank = 3'd1;
      3'b001:  rank = 3'd2;
      3'b011:  rank = 3'd3;
      3'b101:  rank = 3'd4;
      default: rank = 3'd0;
    endcase
    return rank;
  endfunction

endpackage

// File: rtl/arbitro_prioridade_n_seletor.sv
// Combinational selector: highest code among the candidate mask, ties go to
// the first candidate found scanning upward from rr_ptr with wrap-around.
module seletor_maior_prioridade #(
  parameter int N      = 4,
  parameter int CODE_W = 3,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic [N-1:0]        cand,
  input  logic [N*CODE_W-1:0] code,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic                found,
  output logic [IDX_W-1:0]    idx,
  output logic [CODE_W-1:0]   code_sel
);

  logic [CODE_W-1:0] code_ch [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign code_ch[gi] = code[gi*CODE_W +: CODE_W];
    end
  endgenerate

  always_comb begin
    int pos;
    logic [IDX_W-1:0] ch;
    found    = 1'b0;
    idx      = '0;
    code_sel = '0;
    pos      = 0;
    ch       = '0;
    // Strict comparison keeps the earliest index in scan order on ties.
    for (int k = 0; k < N; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N) pos = pos - N;
      ch = IDX_W'(pos);
      if (cand[ch] && (!found || code_ch[ch] > code_sel)) begin
        found    = 1'b1;
        idx      = ch;
        code_sel = code_ch[ch];
      end
    end
  end

endmodule

// File: rtl/arbitro_prioridade_n.sv
// Registered N-channel priority arbiter with hold-until-release, optional
// preemption, optional hold timeout and round-robin tie breaking.
module arbitro_prioridade_n
  import arbitro_pkg::*;
#(
  parameter int N        = 4,
  parameter int CODE_W   = 3,
  parameter int PREEMPT  = 1,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [N*CODE_W-1:0] code,
  input  logic [N-1:0]        release_strobe,
  output logic [N-1:0]        grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic [CODE_W-1:0]   grant_code,
  output logic                busy,
  output logic                preempt,
  output logic [IDX_W-1:0]    preempt_idx,
  output logic [CODE_W-1:0]   preempt_code,
  output logic                timeout,
  output logic                err,
  output logic [IDX_W-1:0]    err_idx
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [N-1:0] ONE_HOT_0 = N'(1);

  state_t state_reg, state_next;
  logic [N-1:0]      grant_reg, grant_next;
  logic [IDX_W-1:0]  grant_idx_reg, grant_idx_next;
  logic [CODE_W-1:0] grant_code_reg, grant_code_next;
  logic              preempt_reg, preempt_next;
  logic [IDX_W-1:0]  preempt_idx_reg, preempt_idx_next;
  logic [CODE_W-1:0] preempt_code_reg, preempt_code_next;
  logic              timeout_reg, timeout_next;
  logic              err_reg, err_next;
  logic [IDX_W-1:0]  err_idx_reg, err_idx_next;
  logic [IDX_W-1:0]  rr_reg, rr_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;

  logic [CODE_W-1:0] code_ch [N];
  logic [N-1:0]      invalid;
  logic [N-1:0]      cand;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [CODE_W-1:0] sel_code;

  // The current owner is masked out so the selector only proposes challengers.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign code_ch[gi] = code[gi*CODE_W +: CODE_W];
      assign invalid[gi] = req[gi] && is_invalid(32'(code_ch[gi]), CODE_W);
      assign cand[gi]    = req[gi] && (code_ch[gi] != CODE_W'(CODE_IDLE)) && !invalid[gi]
                           && !(state_reg == ST_GRANT && grant_idx_reg == IDX_W'(gi));
    end
  endgenerate

  seletor_maior_prioridade #(
    .N      (N),
    .CODE_W (CODE_W),
    .IDX_W  (IDX_W)
  ) u_seletor (
    .cand     (cand),
    .code     (code),
    .rr_ptr   (rr_reg),
    .found    (sel_found),
    .idx      (sel_idx),
    .code_sel (sel_code)
  );

  always_comb begin
    err_next     = |invalid;
    err_idx_next = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (invalid[i]) err_idx_next = IDX_W'(i);
    end
  end

  always_comb begin
    state_next        = state_reg;
    grant_next        = grant_reg;
    grant_idx_next    = grant_idx_reg;
    grant_code_next   = grant_code_reg;
    preempt_next      = 1'b0;
    preempt_idx_next  = preempt_idx_reg;
    preempt_code_next = preempt_code_reg;
    timeout_next      = 1'b0;
    rr_next           = rr_reg;
    hold_next         = hold_reg;

    case (state_reg)
      ST_IDLE: begin
        if (sel_found) begin
          state_next      = ST_GRANT;
          grant_next      = ONE_HOT_0 << sel_idx;
          grant_idx_next  = sel_idx;
          grant_code_next = sel_code;
          hold_next       = '0;
          rr_next         = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      ST_GRANT: begin
        if (release_strobe[grant_idx_reg]) begin
          state_next      = ST_IDLE;
          grant_next      = '0;
          grant_idx_next  = '0;
          grant_code_next = '0;
        end else if (MAX_HOLD != 0 && hold_reg == HOLD_LAST) begin
          state_next      = ST_IDLE;
          grant_next      = '0;
          grant_idx_next  = '0;
          grant_code_next = '0;
          timeout_next    = 1'b1;
        end else if (PREEMPT != 0 && sel_found && sel_code > grant_code_reg) begin
          grant_next        = ONE_HOT_0 << sel_idx;
          grant_idx_next    = sel_idx;
          grant_code_next   = sel_code;
          preempt_next      = 1'b1;
          preempt_idx_next  = grant_idx_reg;
          preempt_code_next = grant_code_reg;
          hold_next         = '0;
          rr_next           = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + 1'b1;
        end else if (hold_reg != '1) begin
          hold_next = hold_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      grant_reg        <= '0;
      grant_idx_reg    <= '0;
      grant_code_reg   <= '0;
      preempt_reg      <= 1'b0;
      preempt_idx_reg  <= '0;
      preempt_code_reg <= '0;
      timeout_reg      <= 1'b0;
      err_reg          <= 1'b0;
      err_idx_reg      <= '0;
      rr_reg           <= '0;
      hold_reg         <= '0;
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      grant_idx_reg    <= grant_idx_next;
      grant_code_reg   <= grant_code_next;
      preempt_reg      <= preempt_next;
      preempt_idx_reg  <= preempt_idx_next;
      preempt_code_reg <= preempt_code_next;
      timeout_reg      <= timeout_next;
      err_reg          <= err_next;
      err_idx_reg      <= err_idx_next;
      rr_reg           <= rr_next;
      hold_reg         <= hold_next;
    end
  end

  assign grant        = grant_reg;
  assign grant_idx    = grant_idx_reg;
  assign grant_code   = grant_code_reg;
  assign busy         = (state_reg == ST_GRANT);
  assign preempt      = preempt_reg;
  assign preempt_idx  = preempt_idx_reg;
  assign preempt_code = preempt_code_reg;
  assign timeout      = timeout_reg;
  assign err          = err_reg;
  assign err_idx      = err_idx_reg;

endmodule
